sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel stage: converts a raster-order 8-bit pixel stream into 3x3 neighbourhood windows.
- Output is packed as the 72-bit bus the Sobel stage consumes directly.
- Holds two image lines in circular line buffers plus a 3x3 shift-register window.
- Emits one valid window per interior pixel, (IMG_W-2)*(IMG_H-2) per frame.

Parameters:
- IMG_W, 100, pixels per line (>=3).
- IMG_H, 100, lines per frame (>=3).
- PIX_W, 8, bits per pixel; window bus is 9*PIX_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  pix_in is valid this cycle.
- in_ready  out  1  block accepts a pixel this cycle. A pixel is accepted when in_valid&&in_ready.
- pix_in  in  PIX_W  raster-order pixel (row-major, top-left first).
- win_out  out  9*PIX_W  packed window, MSB first: {r1c0,r1c1,r1c2,r2c0,r2c1,r2c2,r3c0,r3c1,r3c2}. r1 is the oldest (top) row; c0 is the leftmost column.
- win_valid  out  1  win_out holds a new window this cycle (1-cycle pulse).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, any state):
  - State=IDLE; col/row counters=0; window registers=0.
  - win_out=0, win_valid=0, frame_done=0, in_ready=0.
  - Line-buffer contents need not be cleared.
- States:
  - IDLE: in_ready=0. start -> FILL; counters cleared.
  - FILL: rows 0..1. in_ready=1. Accepted pixel at col=IMG_W-1, row=1 -> RUN.
  - RUN: rows 2..IMG_H-1. in_ready=1. Accepted pixel at col=IMG_W-1, row=IMG_H-1 -> DONE.
  - DONE: in_ready=0; frame_done=1 for exactly this one cycle; next cycle -> IDLE.
- start outside IDLE is ignored.
- Per accepted pixel p at (row, col):
  - Read lb2[col] (two rows up) and lb1[col] (one row up), read-before-write.
  - Write lb2[col]<=lb1[col] and lb1[col]<=p.
  - Shift window left one column. New right column: r1c2=lb2[col], r2c2=lb1[col], r3c2=p.
  - col increments and wraps IMG_W-1 -> 0 with row++.
- win_valid is registered, asserted the cycle after acceptance iff row>=2 && col>=2. It stays 0 for col 0..1, so there is no cross-line window contamination.
- Latency: accepted pixel at edge N -> win_out/win_valid at edge N+1. win_out holds its last value when win_valid=0.
- Stalls: in_valid=0 freezes counters, window and line buffers. No output is produced.
- The downstream Sobel stage has no backpressure, so there is no out_ready.
- Back-to-back frames: a new start is accepted the cycle after DONE. Stale line data is fully overwritten during FILL before any window is emitted.
- Width: counters are $clog2(IMG_W) and $clog2(IMG_H) bits. No arithmetic on pixel data.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W, default IMG_W/IMG_H.
  - State enum {IDLE, FILL, RUN, DONE}.
  - WIN_W=9*PIX_W.
- Sub-module line_buffer:
  - IMG_W x PIX_W, single address, combinational read, synchronous write on we.
  - Instantiated twice (lb1, lb2).

Test Plan (IMG_W=5, IMG_H=5, pixel value = row*5+col):
- start then 25 pixels, in_valid held high -> exactly 9 win_valid pulses. First one, the cycle after pixel 12, gives win_out={0,1,2,5,6,7,10,11,12}. Last one gives {12,13,14,17,18,19,22,23,24}. frame_done pulses once, the cycle after pixel 24 is accepted.
- Line wrap: no win_valid after pixels 15 and 16. After pixel 17, win_out={5,6,7,10,11,12,15,16,17}.
- Random in_valid gaps (about 50% duty) -> identical window sequence to the gap-free run. No win_valid during gap cycles.
- start pulsed mid-frame (RUN) -> ignored, window sequence unchanged. start in IDLE with in_valid high -> first pixel accepted the cycle after start.
- rst asserted after pixel 14, then a new frame with values +100 -> outputs 0 during reset. The new frame's first window is {100,101,102,105,106,107,110,111,112}, with no old data leaking through.
- Two frames back-to-back (start the cycle after DONE), second frame values inverted (255-v) -> second frame's 9 windows are all correct.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front-end window generator.
package sobel_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 100;
    localparam int unsigned IMG_H_DEF = 100;
    localparam int unsigned WIN_W     = 9 * PIX_W;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: combinational read, synchronous write, single address.
module line_buffer #(
    parameter int unsigned Depth = 100,
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Contents are never reset; every slot is rewritten during FILL before use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into packed 3x3 windows, one per interior pixel.
module sobel_window_gen #(
    parameter int unsigned IMG_W = sobel_pkg::IMG_W_DEF,
    parameter int unsigned IMG_H = sobel_pkg::IMG_H_DEF,
    parameter int unsigned PIX_W = sobel_pkg::PIX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PIX_W-1:0]   pix_in_i,
    output logic [9*PIX_W-1:0] win_out_o,
    output logic               win_valid_o,
    output logic               frame_done_o
);

    import sobel_pkg::*;

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    state_e state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Each row register is ordered c0..c2 so packing puts c0 in the MSBs.
    logic [0:2][PIX_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [9*PIX_W-1:0]    win_q, win_d;
    logic                  win_valid_q, win_valid_d;

    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic             accept, col_last, row_last, emit;

    assign accept   = in_valid_i && in_ready_o;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    line_buffer #(
        .Depth (IMG_W),
        .Width (PIX_W),
        .AddrW (CW)
    ) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (pix_in_i),
        .rdata_o (lb1_rd)
    );

    line_buffer #(
        .Depth (IMG_W),
        .Width (PIX_W),
        .AddrW (CW)
    ) u_lb2 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StFill;
            StFill: if (accept && col_last && (row_q == RW'(1))) state_d = StRun;
            StRun:  if (accept && col_last && row_last) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == StFill) || (state_q == StRun);
        frame_done_o = (state_q == StDone);
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        win_d       = win_q;
        win_valid_d = emit;
        if (state_q == StIdle && start_i) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            r1_d = {r1_q[1], r1_q[2], lb2_rd};
            r2_d = {r2_q[1], r2_q[2], lb1_rd};
            r3_d = {r3_q[1], r3_q[2], pix_in_i};
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // Output bus only moves with a valid window, so it holds between pulses.
            if (emit) begin
                win_d = {r1_d, r2_d, r3_d};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win_out_o   = win_q;
    assign win_valid_o = win_valid_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed-sequence bench with random stalls, checked against a 2D-image window model.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  pix_in = '0;
    logic [71:0] win_out;
    logic        win_valid;
    logic        frame_done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  img [N];
    logic [71:0] exp_win = '0;

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .pix_in_i     (pix_in),
        .win_out_o    (win_out),
        .win_valid_o  (win_valid),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 3x3 neighbourhood ending at (r, c) taken straight from the stored image.
    function automatic logic [71:0] window(input int r, input int c);
        logic [71:0] w = '0;
        for (int i = r - 2; i <= r; i++)
            for (int j = c - 2; j <= c; j++)
                w = (w << 8) | 72'(img[i * W + j]);
        return w;
    endfunction

    task automatic run_frame(input int base, input bit inv, input int gap_pct,
                             input bit mid_start, input int stop_at);
        int acc_n = 0;
        int nwin = 0;
        int cyc = 0;
        bit v, ev;
        for (int i = 0; i < N; i++) img[i] = inv ? 8'(255 - i) : 8'(base + i);
        start = 1'b1;
        in_valid = 1'b1;
        pix_in = img[0];
        chk("ready_idle", 72'(in_ready), 72'(0));
        tick();
        start = 1'b0;
        chk("wv_after_start", 72'(win_valid), 72'(0));
        while (acc_n < stop_at) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            pix_in = img[acc_n];
            start = mid_start && (acc_n == 13);
            chk("ready_frame", 72'(in_ready), 72'(1));
            tick();
            ev = 1'b0;
            if (v) begin
                if (acc_n / W >= 2 && acc_n % W >= 2) begin
                    ev = 1'b1;
                    exp_win = window(acc_n / W, acc_n % W);
                end
                acc_n++;
            end
            if (ev) nwin++;
            chk("win_valid", 72'(win_valid), 72'(ev));
            chk("win_out", win_out, exp_win);
            chk("frame_done", 72'(frame_done), 72'(acc_n == N));
            cyc++;
            if (cyc > 2000) begin
                chk("cycle_budget", 72'(cyc), 72'(2000));
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (stop_at == N) begin
            chk("n_windows", 72'(nwin), 72'(9));
            chk("ready_done", 72'(in_ready), 72'(0));
            tick();
            chk("frame_done_end", 72'(frame_done), 72'(0));
            chk("wv_idle", 72'(win_valid), 72'(0));
            chk("win_hold", win_out, exp_win);
        end
    endtask

    initial begin
        #1;
        chk("rst_win_out", win_out, 72'(0));
        chk("rst_win_valid", 72'(win_valid), 72'(0));
        chk("rst_ready", 72'(in_ready), 72'(0));
        chk("rst_frame_done", 72'(frame_done), 72'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", 72'(in_ready), 72'(0));

        // Gap-free frame, in_valid already high on the start cycle.
        run_frame(0, 1'b0, 0, 1'b0, N);
        tick();
        // Random stalls around 50%, with a start pulse in the middle of RUN.
        run_frame(0, 1'b0, 50, 1'b1, N);
        tick();
        // Abort after 15 pixels with an asynchronous reset.
        run_frame(0, 1'b0, 0, 1'b0, 15);
        rst = 1'b1;
        #1;
        chk("mid_rst_win_out", win_out, 72'(0));
        chk("mid_rst_win_valid", 72'(win_valid), 72'(0));
        chk("mid_rst_ready", 72'(in_ready), 72'(0));
        chk("mid_rst_frame_done", 72'(frame_done), 72'(0));
        exp_win = '0;
        tick();
        tick();
        chk("rst_hold_win_out", win_out, 72'(0));
        rst = 1'b0;
        tick();
        // Fresh frame after reset, then an inverted frame back-to-back.
        run_frame(100, 1'b0, 30, 1'b0, N);
        run_frame(0, 1'b1, 0, 1'b0, N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
